// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared width codes, FSM encoding and request checks for the load/store unit
// Purpose: constants and helpers imported by load_store_unit and lsu_align.
// Contents: RV32I funct3 width codes, lsu_state_e FSM encoding,
//           funct3_legal() and misaligned() acceptance checks.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic funct3_legal(input logic store, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_H, F3_HU: bad = lane[0];
      F3_W:        bad = (lane != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane extract/extend for loads and lane merge for stores
// Purpose: purely combinational lane handling around the buffered memory word.
// Ports:
//   funct3     in  3  width code of the latched request
//   lane       in  2  byte offset addr[1:0]
//   word       in  32 buffered memory word
//   wdata      in  32 right-aligned store data
//   load_data  out 32 extended load result
//   merge_word out 32 word with the store lanes replaced (wdata itself for W)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_word
);

  logic [4:0]  shamt;
  logic [15:0] low_half;
  logic [31:0] mask;

  assign shamt    = {lane, 3'b000};
  // Selected lane moved down to bit 0; only the low half is ever needed.
  assign low_half = 16'(word >> shamt);

  always_comb begin
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{low_half[7]}}, low_half[7:0]};
      F3_BU:   load_data = {24'b0, low_half[7:0]};
      F3_H:    load_data = {{16{low_half[15]}}, low_half};
      F3_HU:   load_data = {16'b0, low_half};
      default: load_data = word;
    endcase
  end

  always_comb begin
    mask = 32'hFFFF_FFFF;
    case (funct3)
      F3_B:    mask = 32'h0000_00FF << shamt;
      F3_H:    mask = 32'h0000_FFFF << shamt;
      default: mask = 32'hFFFF_FFFF;
    endcase
    merge_word = (word & ~mask) | ((wdata << shamt) & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with read-modify-write sub-word stores
// Purpose: accepts one request at a time, accesses a word-wide memory, returns a one-cycle response.
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_store, req_funct3     store flag and RV32I width code
//   req_addr, req_wdata       byte address and right-aligned store data
//   resp_valid                one-cycle response pulse
//   resp_rdata, resp_err      extended load data / error flag (0 outside the response)
//   mem_we, mem_a, mem_wd     word write enable, word-aligned address, write word
//   mem_rd                    combinational read word
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  lsu_state_e  state_q, state_d;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] buf_q;
  logic        err_q;

  logic        accept;
  logic        acc_err;
  logic [31:0] load_data;
  logic [31:0] merge_word;

  assign accept  = (state_q == IDLE) && req_valid;
  assign acc_err = !funct3_legal(req_store, req_funct3)
                 || misaligned(req_funct3, req_addr[1:0])
                 || ({2'b00, req_addr[31:2]} >= MEM_WORDS_W);

  lsu_align u_align (
    .funct3     (funct3_q),
    .lane       (addr_q[1:0]),
    .word       (buf_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_word (merge_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      buf_q    <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        store_q  <= req_store;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= acc_err;
      end
      if (state_q == RD) begin
        buf_q <= mem_rd;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    mem_we     = 1'b0;
    mem_a      = 32'd0;
    mem_wd     = 32'd0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (acc_err) begin
            state_d = RESP;
          end else if (req_store && (req_funct3 == F3_W)) begin
            // Full-word store needs no read of the old word.
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        mem_a   = {addr_q[31:2], 2'b00};
        state_d = store_q ? WR : RESP;
      end
      WR: begin
        mem_we  = 1'b1;
        mem_a   = {addr_q[31:2], 2'b00};
        mem_wd  = merge_word;
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || store_q) ? 32'd0 : load_data;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024: number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk  input  1: clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1: core presents a memory request.
REQ-005 SHALL have port req_ready  output  1: unit can accept a request.
REQ-006 SHALL have port req_store  input  1: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3: RV32I width code (0 B, 1 H, 2 W, 4 BU, 5 HU).
REQ-008 SHALL have port req_addr  input  32: byte address.
REQ-009 SHALL have port req_wdata  input  32: store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1: one-cycle response pulse.
REQ-011 SHALL have port resp_rdata  output  32: extended load result; 0 for stores and errors.
REQ-012 SHALL have port resp_err  output  1: misaligned, illegal funct3, or out-of-range access.
REQ-013 SHALL have port mem_we  output  1: word write enable to the memory.
REQ-014 SHALL have port mem_a  output  32: word-aligned byte address to the memory.
REQ-015 SHALL have port mem_wd  output  32: write word to the memory.
REQ-016 SHALL have port mem_rd  input  32: combinational read word from the memory.

Function
REQ-017 SHALL implement the FSM states IDLE, RD, WR, and RESP.
REQ-018 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both 1, and all request fields are latched at that edge.
REQ-019 SHALL flag an error on acceptance when H/HU/SH has addr[0]=1, when W/SW has addr[1:0]!=0, when funct3 is illegal (loads 3, 6, 7; stores >2), or when addr>>2 >= MEM_WORDS.
REQ-020 SHALL, on an erroring request, transition IDLE->RESP, issue no memory access, and set resp_err=1.
REQ-021 SHALL route a load through IDLE->RD->RESP: in RD, sample mem_rd into a word buffer.
REQ-022 SHALL route SW through IDLE->WR->RESP.
REQ-023 SHALL route SB/SH through IDLE->RD->WR->RESP (read-modify-write): merge the byte/half into the buffered word at lane addr[1:0] and leave other lanes unchanged.
REQ-024 SHALL, in RESP, drive resp_valid=1 for exactly one cycle, then return to IDLE; the next request is accepted no earlier than the following cycle.
REQ-025 SHALL meet these latencies, acceptance edge = cycle 0: LW/LB/LH resp_valid in cycle 2; SW in cycle 2; SB/SH in cycle 3; error in cycle 1.
REQ-026 SHALL drive mem_a={addr[31:2],2'b00} in RD and WR, and 0 otherwise.
REQ-027 SHALL drive mem_we=1 only in WR, with mem_wd the merged or full word; mem_wd SHALL be 0 outside WR.
REQ-028 SHALL form load results from the byte lane selected by addr[1:0]: B/H sign-extend, BU/HU zero-extend, W passes the word unchanged.
REQ-029 SHALL hold resp_rdata and resp_err at 0 outside RESP.

Reset
REQ-030 SHALL, on rst, force the FSM to IDLE and clear the buffer, latched request, resp_valid, resp_rdata, resp_err, mem_we, mem_a and mem_wd to 0; req_ready=1 once rst deasserts.
REQ-031 SHALL, when reset is asserted mid-operation, abandon the operation with no write issued and no response pulse.

Structure
REQ-032 SHALL place funct3 width constants and the FSM state encoding in shared package lsu_pkg.
REQ-033 SHALL implement lane extract/extend and lane merge in one combinational sub-module, lsu_align.

Verification
REQ-034 SHALL verify: memory word0=0x8899AABB; LB addr 0x1 -> cycle 2 resp_rdata=0xFFFFFFAA, err=0.
REQ-035 SHALL verify: same word; LHU addr 0x2 -> resp_rdata=0x00008899; LH addr 0x3 -> resp_err=1 in cycle 1, no mem access.
REQ-036 SHALL verify: SB addr 0x6, wdata 0x123456CC over word1=0x11223344 -> mem_we pulse in cycle 2, word1=0x11CC3344, resp_valid in cycle 3.
REQ-037 SHALL verify: SW addr 0x1000 (MEM_WORDS=1024) -> resp_err=1, mem_we never asserted.
REQ-038 SHALL verify: rst pulsed while in RD of an SH -> no mem_we, no resp_valid, req_ready=1 after release.
REQ-039 SHALL verify: req_valid held high continuously for back-to-back LW -> req_ready low in RD and RESP, each request answered exactly once.
